// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter -- gated rising-edge counter, core of the lab frequency counter.
//
// The signal under measurement drives `clock`; `reset` doubles as the gate.
// While the gate is low the count and overflow flag are cleared and held at
// zero (asynchronously). While the gate is high every rising clock edge adds
// one to the count, so the value at the end of a gate of length T is f*T.
// The count saturates at 2^WIDTH-1 instead of wrapping, and the sticky
// `overflow` flag records that saturation happened during this window.
//
// Ports:
//   reset    in   1      async active-low clear / measurement gate
//   clock    in   1      signal under measurement, rising edges counted
//   countOut out  WIDTH  running edge count since gate opened (unsigned)
//   overflow out  1      sticky: set once the count has saturated
// ---------------------------------------------------------------------------
module counter #(
   parameter int WIDTH = 32
) (
   input  logic             reset,
   input  logic             clock,
   output logic [WIDTH-1:0] countOut,
   output logic             overflow
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             ovf_q;
   logic             ovf_d;

   // Saturating increment: an all-ones count stays all-ones.
   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      if (&v) begin
         return v;
      end
      return v + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Next-state: the edge that would wrap the count raises overflow instead.
   always_comb begin
      count_d = sat_inc(count_q);
      ovf_d   = ovf_q | (&count_q);
   end

   // Count and flag clear immediately when the gate closes; the gate is the
   // reset, so the data path is cleared along with the control flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign countOut = count_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_counter.sv
// ---------------------------------------------------------------------------
// tb_counter -- directed bench for the gated edge counter.
// Time base: 10 simulation units per millisecond.
// Three instances run in parallel:
//   u_dut50  WIDTH=32, 50 Hz clock  : gate windows, gate-low hold, mid-window reset
//   u_dut100 WIDTH=32, 100 Hz clock : one 1 s gate
//   u_dut4   WIDTH=4, fast clock    : saturation and sticky overflow
// ---------------------------------------------------------------------------
module tb_counter;

   localparam int MS = 10;

   logic        clk50  = 1'b0;
   logic        clk100 = 1'b0;
   logic        clk4   = 1'b0;
   logic        r50    = 1'b0;
   logic        r100   = 1'b0;
   logic        r4     = 1'b0;
   logic [31:0] cnt50;
   logic [31:0] cnt100;
   logic [3:0]  cnt4;
   logic        ovf50;
   logic        ovf100;
   logic        ovf4;

   int n_checks = 0;
   int n_errors = 0;

   always #(10 * MS) clk50  = ~clk50;   // 50 Hz: rising at 10, 30, ... ms
   always #(5 * MS)  clk100 = ~clk100;  // 100 Hz: rising at 5, 15, ... ms
   always #10        clk4   = ~clk4;    // rising at 10, 30, 50, ... units

   counter #(.WIDTH(32)) u_dut50 (
      .reset(r50), .clock(clk50), .countOut(cnt50), .overflow(ovf50)
   );
   counter #(.WIDTH(32)) u_dut100 (
      .reset(r100), .clock(clk100), .countOut(cnt100), .overflow(ovf100)
   );
   counter #(.WIDTH(4)) u_dut4 (
      .reset(r4), .clock(clk4), .countOut(cnt4), .overflow(ovf4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic wait_until(input longint t);
      if (t > longint'($time)) #(t - longint'($time));
   endtask

   initial begin
      fork
         // ---------------- 50 Hz gate sequence ----------------
         begin
            wait_until(MS / 2);
            chk("50_reset_cnt", 64'(cnt50), 64'd0);
            chk("50_reset_ovf", 64'(ovf50), 64'd0);
            wait_until(1 * MS);
            r50 = 1'b1;                        // gate open before first edge at 10 ms
            wait_until(999 * MS);
            chk("50_first_window", 64'(cnt50), 64'd50);
            chk("50_first_ovf", 64'(ovf50), 64'd0);
            wait_until(1000 * MS);
            r50 = 1'b0;
            wait_until(1000 * MS + 5);         // well before the 1010 ms edge
            chk("50_async_clear", 64'(cnt50), 64'd0);
            for (int w = 0; w < 10; w++) begin
               longint base;
               base = longint'(2000 + 2000 * w) * MS;
               wait_until(base - 1 * MS);
               chk("50_gate_low_hold", 64'(cnt50), 64'd0);
               wait_until(base);
               r50 = 1'b1;
               wait_until(base + 11 * MS);
               chk("50_first_edge", 64'(cnt50), 64'd1);
               wait_until(base + 999 * MS);
               chk("50_window", 64'(cnt50), 64'd50);
               wait_until(base + 1000 * MS);
               r50 = 1'b0;
               wait_until(base + 1000 * MS + 5);
               chk("50_close_clear", 64'(cnt50), 64'd0);
            end
            // Mid-window reset: gate opens at 22000 ms, pulled low 500 ms later.
            wait_until(22000 * MS);
            r50 = 1'b1;
            wait_until(22499 * MS);
            chk("50_mid_partial", 64'(cnt50), 64'd25);
            wait_until(22500 * MS);
            r50 = 1'b0;
            wait_until(22500 * MS + 5);
            chk("50_mid_clear", 64'(cnt50), 64'd0);
         end
         // ---------------- 100 Hz, 1 s gate ----------------
         begin
            wait_until(1 * MS);
            r100 = 1'b1;
            wait_until(1000 * MS + 5);
            chk("100_gate_close", 64'(cnt100), 64'd100);
            chk("100_ovf", 64'(ovf100), 64'd0);
            wait_until(1001 * MS);
            r100 = 1'b0;
            wait_until(1001 * MS + 5);
            chk("100_clear", 64'(cnt100), 64'd0);
         end
         // ---------------- WIDTH=4 saturation ----------------
         begin
            wait_until(5);
            r4 = 1'b1;
            for (int k = 1; k <= 20; k++) begin
               wait_until(longint'(20 * k - 5));  // 5 units after edge k
               chk("w4_cnt", 64'(cnt4), (k > 15) ? 64'd15 : 64'(k));
               chk("w4_ovf", 64'(ovf4), (k >= 16) ? 64'd1 : 64'd0);
            end
            wait_until(415);
            r4 = 1'b0;
            wait_until(418);
            chk("w4_rst_cnt", 64'(cnt4), 64'd0);
            chk("w4_rst_ovf", 64'(ovf4), 64'd0);
            wait_until(425);
            r4 = 1'b1;
            wait_until(435);
            chk("w4_restart_cnt", 64'(cnt4), 64'd1);
            chk("w4_restart_ovf", 64'(ovf4), 64'd0);
         end
      join
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
